bsg_axil_master_cmd_bridge: RTL and testbench
=============================================

// Module: bsg_axil_master_cmd_bridge
// PURPOSE
//  Parametrised AXI4-Lite master for cosim/host bridges: turns a valid/ready
//  command stream (read or write) into AXI-Lite transactions, with pipelining
//  and in-order buffered responses. Unlike the plain DPI pin bridge, it owns
//  the handshakes. It supports up to max_outstanding_p same-type transactions,
//  independent AW/W acceptance and a response-timeout watchdog.
// PARAMETERS
//  addr_width_p      32  AXI address width
//  data_width_p      32  AXI data width; strb width = data_width_p/8
//  max_outstanding_p  4  max in-flight transactions; also resp FIFO depth (>=1)
//  timeout_cycles_p   0  cycles without B/R while outstanding before error; 0 = off
// PORTS
//  aclk_i        in   1    clock
//  aresetn_i     in   1    async active-low reset
//  cmd_v_i       in   1    command valid
//  cmd_ready_o   out  1    command accepted when v&ready
//  cmd_we_i      in   1    1=write, 0=read
//  cmd_addr_i    in   A    address
//  cmd_data_i    in   D    write data
//  cmd_strb_i    in   D/8  write strobes
//  resp_v_o      out  1    response valid
//  resp_yumi_i   in   1    response consumed (only when resp_v_o)
//  resp_we_o     out  1    response type (1 = B, 0 = R)
//  resp_data_o   out  D    rdata (0 for writes)
//  resp_err_o    out  2    bresp/rresp
//  timeout_o     out  1    sticky watchdog error; cleared only by reset
//  awaddr_o/awprot_o(3)/awvalid_o out, awready_i in; wdata_o/wstrb_o/wvalid_o out,
//  wready_i in; bresp_i(2)/bvalid_i in, bready_o out; araddr_o/arprot_o(3)/
//  arvalid_o out, arready_i in; rdata_i/rresp_i(2)/rvalid_i in, rready_o out
// BEHAVIOUR
//  - Reset (async assert, sync release): all *valid_o, bready_o, rready_o,
//    resp_v_o and timeout_o = 0. Addr/data/prot regs = 0. Counters = 0.
//    FIFO empty. Mode = READ.
//  - *prot_o are always 3'b000.
//  - Issue regs hold one command. cmd_ready_o = issue reg empty &
//    (outstanding + fifo_count) < max_outstanding_p &
//    (outstanding == 0 | cmd_we_i == mode).
//  - A type switch waits until outstanding drains to 0, which keeps order.
//  - A command accepted in cycle N drives valid outputs, registered, in N+1.
//    Write: awvalid_o and wvalid_o both assert. Each drops on its own
//    handshake: aw_done/w_done flags.
//  - The issue reg frees when both flags are set, or on arvalid&arready. It can
//    accept a new command in the same cycle it frees (back-to-back issue).
//  - Valid outputs and payloads are stable while valid and not ready (AXI rule).
//  - outstanding++ on cmd accept, outstanding-- on B/R handshake. A
//    simultaneous inc and dec leaves it unchanged.
//  - bready_o = (mode==WRITE) & FIFO not full. rready_o = (mode==READ) &
//    FIFO not full. Credit check guarantees FIFO never overflows.
//  - B/R handshake pushes {we,data,resp} into FIFO; resp_v_o visible next cycle.
//  - FIFO push and pop in the same cycle is allowed, including full and
//    empty-with-bypass-disabled cases.
//  - Unexpected bvalid_i while in READ mode or rvalid_i while in WRITE mode:
//    never accepted; the ready stays low.
//  - Watchdog: counter clears on any B/R handshake or when outstanding == 0,
//    else increments. When it reaches timeout_cycles_p, timeout_o sets and
//    stays set; the block keeps operating.
//  - Reset mid-transaction drops all valids at once and discards the FIFO
//    and in-flight state.
// TESTING
//  - Single write 0x10 <- 0xDEADBEEF strb 0xF, awready = wready = 1.
//    Required: aw/w valid at N+1; bvalid → resp_v = 1, we = 1, err = 0.
//  - Write with awready at N+1 but wready at N+4. Required: awvalid drops at
//    N+2, wvalid holds data until N+4, and exactly one outstanding is counted.
//  - 6 back-to-back reads, max_outstanding_p = 4, rvalid withheld. Required:
//    cmd_ready low after 4. Released rdata 1..4 → responses in order 1..4,
//    then reads 5 and 6 issue.
//  - Read followed by write. Required: the write is not accepted until the R
//    handshake. Response order is R then B.
//  - resp_yumi held 0 with FIFO full. Required: rready/bready = 0 and no loss.
//    Then yumi = 1 drains one per cycle.
//  - timeout_cycles_p = 8, read with no rvalid. Required: timeout_o = 1 at
//    cycle 8 after issue. Mid-read aresetn = 0 → all outputs back to 0 at once.

Source files
------------

// File: rtl/bsg_axil_master_cmd_bridge.sv
// AXI4-Lite master: turns a valid/ready command stream into AXI-Lite read/write
// transactions, tracks outstanding credits and returns responses in order.
module bsg_axil_master_cmd_bridge #(
    parameter int addr_width_p      = 32,
    parameter int data_width_p      = 32,
    parameter int max_outstanding_p = 4,
    parameter int timeout_cycles_p  = 0
) (
    input  logic                      aclk_i,
    input  logic                      aresetn_i,

    input  logic                      cmd_v_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [addr_width_p-1:0]   cmd_addr_i,
    input  logic [data_width_p-1:0]   cmd_data_i,
    input  logic [data_width_p/8-1:0] cmd_strb_i,

    output logic                      resp_v_o,
    input  logic                      resp_yumi_i,
    output logic                      resp_we_o,
    output logic [data_width_p-1:0]   resp_data_o,
    output logic [1:0]                resp_err_o,
    output logic                      timeout_o,

    output logic [addr_width_p-1:0]   awaddr_o,
    output logic [2:0]                awprot_o,
    output logic                      awvalid_o,
    input  logic                      awready_i,

    output logic [data_width_p-1:0]   wdata_o,
    output logic [data_width_p/8-1:0] wstrb_o,
    output logic                      wvalid_o,
    input  logic                      wready_i,

    input  logic [1:0]                bresp_i,
    input  logic                      bvalid_i,
    output logic                      bready_o,

    output logic [addr_width_p-1:0]   araddr_o,
    output logic [2:0]                arprot_o,
    output logic                      arvalid_o,
    input  logic                      arready_i,

    input  logic [data_width_p-1:0]   rdata_i,
    input  logic [1:0]                rresp_i,
    input  logic                      rvalid_i,
    output logic                      rready_o
);

    localparam int strb_w = data_width_p / 8;
    localparam int cnt_w  = $clog2(max_outstanding_p + 1);
    localparam int ptr_w  = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam int ent_w  = 1 + data_width_p + 2;

    localparam logic [cnt_w:0]   credit_max = (cnt_w+1)'(max_outstanding_p);
    localparam logic [cnt_w-1:0] fifo_max   = cnt_w'(max_outstanding_p);
    localparam logic [ptr_w-1:0] ptr_last   = ptr_w'(max_outstanding_p - 1);

    typedef enum logic {MODE_READ = 1'b0, MODE_WRITE = 1'b1} mode_e;

    mode_e                mode_q, mode_d;
    logic                 run_q, run_d;
    logic                 awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic [addr_width_p-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [data_width_p-1:0] wdata_q, wdata_d;
    logic [strb_w-1:0]    wstrb_q, wstrb_d;
    logic [cnt_w-1:0]     outstanding_q, outstanding_d;
    logic [cnt_w-1:0]     fifo_cnt_q, fifo_cnt_d;
    logic [ptr_w-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ent_w-1:0]     mem_q [max_outstanding_p];

    logic aw_hold, w_hold, ar_hold, issue_free, credit_ok, mode_ok, accept;
    logic fifo_full, b_hs, r_hs, push, pop, dec;
    logic [cnt_w:0]       in_use;
    logic [ent_w-1:0]     push_ent;

    // A channel still "holds" the issue register while its valid is up and not taken.
    always_comb begin
        aw_hold     = awvalid_q & ~awready_i;
        w_hold      = wvalid_q  & ~wready_i;
        ar_hold     = arvalid_q & ~arready_i;
        issue_free  = ~(aw_hold | w_hold | ar_hold);
        in_use      = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
        credit_ok   = in_use < credit_max;
        mode_ok     = (outstanding_q == '0) | (cmd_we_i == mode_q);
        cmd_ready_o = run_q & issue_free & credit_ok & mode_ok;
        accept      = cmd_v_i & cmd_ready_o;

        fifo_full   = fifo_cnt_q == fifo_max;
        bready_o    = run_q & (mode_q == MODE_WRITE) & ~fifo_full;
        rready_o    = run_q & (mode_q == MODE_READ)  & ~fifo_full;
        b_hs        = bvalid_i & bready_o;
        r_hs        = rvalid_i & rready_o;
        push        = b_hs | r_hs;
        dec         = push & (outstanding_q != '0);
        resp_v_o    = fifo_cnt_q != '0;
        pop         = resp_yumi_i & resp_v_o;
        push_ent    = b_hs ? {1'b1, {data_width_p{1'b0}}, bresp_i}
                           : {1'b0, rdata_i, rresp_i};
    end

    always_comb begin
        run_d         = 1'b1;
        mode_d        = mode_q;
        awvalid_d     = aw_hold;
        wvalid_d      = w_hold;
        arvalid_d     = ar_hold;
        awaddr_d      = awaddr_q;
        araddr_d      = araddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        outstanding_d = outstanding_q;
        fifo_cnt_d    = fifo_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (accept) begin
            mode_d = mode_e'(cmd_we_i);
            if (cmd_we_i) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                awaddr_d  = cmd_addr_i;
                wdata_d   = cmd_data_i;
                wstrb_d   = cmd_strb_i;
            end else begin
                arvalid_d = 1'b1;
                araddr_d  = cmd_addr_i;
            end
        end

        case ({accept, dec})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase

        if (push) wr_ptr_d = (wr_ptr_q == ptr_last) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == ptr_last) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
            2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            run_q         <= 1'b0;
            mode_q        <= MODE_READ;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            awaddr_q      <= '0;
            araddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            run_q         <= run_d;
            mode_q        <= mode_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            arvalid_q     <= arvalid_d;
            awaddr_q      <= awaddr_d;
            araddr_q      <= araddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            outstanding_q <= outstanding_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Response storage is data only; occupancy is tracked by fifo_cnt_q.
    always_ff @(posedge aclk_i) begin
        if (push) mem_q[wr_ptr_q] <= push_ent;
    end

    assign {resp_we_o, resp_data_o, resp_err_o} = mem_q[rd_ptr_q];

    assign awvalid_o = awvalid_q;
    assign wvalid_o  = wvalid_q;
    assign arvalid_o = arvalid_q;
    assign awaddr_o  = awaddr_q;
    assign araddr_o  = araddr_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;
    assign awprot_o  = 3'b000;
    assign arprot_o  = 3'b000;

    if (timeout_cycles_p > 0) begin : g_wd
        localparam int wd_w = $clog2(timeout_cycles_p + 1);
        localparam logic [wd_w-1:0] wd_max = wd_w'(timeout_cycles_p);
        logic [wd_w-1:0] wd_q, wd_d;
        logic            timeout_q, timeout_d;

        // Counts idle cycles while something is in flight; saturates at the limit.
        always_comb begin
            wd_d = wd_q;
            if (push || outstanding_q == '0) wd_d = '0;
            else if (wd_q != wd_max)         wd_d = wd_q + 1'b1;
            timeout_d = timeout_q | (wd_d == wd_max);
        end

        always_ff @(posedge aclk_i or negedge aresetn_i) begin
            if (!aresetn_i) begin
                wd_q      <= '0;
                timeout_q <= 1'b0;
            end else begin
                wd_q      <= wd_d;
                timeout_q <= timeout_d;
            end
        end

        assign timeout_o = timeout_q;
    end else begin : g_no_wd
        assign timeout_o = 1'b0;
    end

endmodule

// File: tb/tb_bsg_axil_master_cmd_bridge.sv
// Bench for bsg_axil_master_cmd_bridge: directed corner cases plus random
// traffic, against a memory-based reference model and an AXI-Lite slave model.
module tb_bsg_axil_master_cmd_bridge;

    typedef struct packed {
        logic        we;
        logic [31:0] data;
        logic [1:0]  err;
    } rsp_t;

    logic        aclk_i = 1'b0;
    logic        aresetn_i = 1'b1;
    logic        cmd_v_i = 1'b0, cmd_ready_o, cmd_we_i = 1'b0;
    logic [31:0] cmd_addr_i = '0, cmd_data_i = '0;
    logic [3:0]  cmd_strb_i = '0;
    logic        resp_v_o, resp_yumi_i = 1'b0, resp_we_o;
    logic [31:0] resp_data_o;
    logic [1:0]  resp_err_o;
    logic        timeout_o;
    logic [31:0] awaddr_o, wdata_o, araddr_o;
    logic [2:0]  awprot_o, arprot_o;
    logic [3:0]  wstrb_o;
    logic        awvalid_o, awready_i = 1'b0, wvalid_o, wready_i = 1'b0;
    logic [1:0]  bresp_i = '0, rresp_i = '0;
    logic        bvalid_i = 1'b0, bready_o, arvalid_o, arready_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic        rvalid_i = 1'b0, rready_o;

    bsg_axil_master_cmd_bridge #(
        .addr_width_p(32), .data_width_p(32),
        .max_outstanding_p(4), .timeout_cycles_p(8)
    ) dut (
        .aclk_i(aclk_i), .aresetn_i(aresetn_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i), .cmd_strb_i(cmd_strb_i),
        .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi_i), .resp_we_o(resp_we_o),
        .resp_data_o(resp_data_o), .resp_err_o(resp_err_o), .timeout_o(timeout_o),
        .awaddr_o(awaddr_o), .awprot_o(awprot_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .araddr_o(araddr_o), .arprot_o(arprot_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    always #5 aclk_i = ~aclk_i;

    int checks = 0;
    int failures = 0;

    // knobs: rdy_mode 0=main drives AW/W/AR readies, 1=random, 2=always;
    // yumi_mode 0=never, 1=random, 2=always
    int   rdy_mode = 2;
    int   yumi_mode = 2;
    bit   b_hold = 0, r_hold = 0;

    rsp_t        exp_q [$];
    logic [31:0] rmem [16];
    logic [31:0] smem [16];

    logic [31:0] aw_q [$];
    logic [31:0] wd_q [$];
    logic [3:0]  ws_q [$];
    logic [1:0]  b_q  [$];
    logic [33:0] r_q  [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++) if (strb[b]) res[8*b +: 8] = nw[8*b +: 8];
        return res;
    endfunction

    // Slave: records handshakes at negedge, drives responses just after posedge.
    initial begin : slave
        bit b_keep, r_keep;
        b_keep = 0;
        r_keep = 0;
        forever begin
            @(negedge aclk_i);
            if (!aresetn_i) begin
                aw_q.delete(); wd_q.delete(); ws_q.delete(); b_q.delete(); r_q.delete();
                b_keep = 0;
                r_keep = 0;
            end else begin
                if (bvalid_i && bready_o) void'(b_q.pop_front());
                if (rvalid_i && rready_o) void'(r_q.pop_front());
                b_keep = bvalid_i && !bready_o;
                r_keep = rvalid_i && !rready_o;
                if (awvalid_o && awready_i) aw_q.push_back(awaddr_o);
                if (wvalid_o && wready_i) begin
                    wd_q.push_back(wdata_o);
                    ws_q.push_back(wstrb_o);
                end
                if (arvalid_o && arready_i)
                    r_q.push_back({smem[araddr_o[5:2]], araddr_o[3:2]});
                while (aw_q.size() > 0 && wd_q.size() > 0) begin
                    logic [31:0] a;
                    a = aw_q.pop_front();
                    smem[a[5:2]] = merge(smem[a[5:2]], wd_q.pop_front(), ws_q.pop_front());
                    b_q.push_back(a[3:2]);
                end
            end
            @(posedge aclk_i);
            #1;
            if (rdy_mode == 1) begin
                awready_i = ($urandom % 3) != 0;
                wready_i  = ($urandom % 3) != 0;
                arready_i = ($urandom % 3) != 0;
            end else if (rdy_mode == 2) begin
                awready_i = 1'b1;
                wready_i  = 1'b1;
                arready_i = 1'b1;
            end
            bvalid_i = (b_q.size() > 0) && !b_hold && (b_keep || ($urandom % 2) == 0);
            bresp_i  = (b_q.size() > 0) ? b_q[0] : 2'b00;
            rvalid_i = (r_q.size() > 0) && !r_hold && (r_keep || ($urandom % 2) == 0);
            rdata_i  = (r_q.size() > 0) ? r_q[0][33:2] : 32'h0;
            rresp_i  = (r_q.size() > 0) ? r_q[0][1:0] : 2'b00;
        end
    end

    // Monitor: compares every consumed response against the scoreboard head.
    initial begin : monitor
        forever begin
            @(negedge aclk_i);
            if (aresetn_i && resp_v_o && resp_yumi_i) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", {resp_we_o, resp_data_o, resp_err_o}, 64'hDEAD_0000_0000);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("resp", {resp_we_o, resp_data_o, resp_err_o}, e);
                end
            end
            @(posedge aclk_i);
            #1;
            resp_yumi_i = aresetn_i && resp_v_o &&
                          (yumi_mode == 2 || (yumi_mode == 1 && ($urandom % 2) == 0));
        end
    end

    // Called at posedge+1; returns at posedge+1 with cmd_v dropped.
    task automatic issue(input logic we, input logic [3:0] idx, input logic [31:0] data,
                         input logic [3:0] strb, input int max_cyc, output bit ok);
        ok = 0;
        cmd_v_i    = 1'b1;
        cmd_we_i   = we;
        cmd_addr_i = {26'h0, idx, 2'b00};
        cmd_data_i = data;
        cmd_strb_i = strb;
        for (int c = 0; c < max_cyc && !ok; c++) begin
            @(negedge aclk_i);
            if (cmd_ready_o) begin
                ok = 1;
                if (we) begin
                    rmem[idx] = merge(rmem[idx], data, strb);
                    exp_q.push_back('{we: 1'b1, data: 32'h0, err: idx[1:0]});
                end else begin
                    exp_q.push_back('{we: 1'b0, data: rmem[idx], err: idx[1:0]});
                end
            end
        end
        @(posedge aclk_i);
        #1;
        cmd_v_i = 1'b0;
    endtask

    task automatic reset_dut(input bit do_chk);
        aresetn_i = 1'b0;
        cmd_v_i   = 1'b0;
        exp_q.delete();
        rdy_mode  = 2;
        yumi_mode = 2;
        b_hold    = 0;
        r_hold    = 0;
        for (int i = 0; i < 16; i++) begin
            rmem[i] = 32'(i);
            smem[i] = 32'(i);
        end
        #1;
        if (do_chk) begin
            chk("rst_valids", {awvalid_o, wvalid_o, arvalid_o, resp_v_o}, 64'h0);
            chk("rst_readies", {bready_o, rready_o}, 64'h0);
            chk("rst_timeout", timeout_o, 64'h0);
            chk("rst_addr", {awaddr_o, araddr_o}, 64'h0);
            chk("rst_wdata", {wdata_o, wstrb_o, awprot_o, arprot_o}, 64'h0);
        end
        repeat (3) @(posedge aclk_i);
        #1;
        aresetn_i = 1'b1;
        @(posedge aclk_i);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge aclk_i);
            #1;
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'h0);
        repeat (5) @(posedge aclk_i);
        #1;
    endtask

    initial begin : global_guard
        #600000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        bit ok;
        #2;
        reset_dut(1);

        // single write, both readies high
        issue(1'b1, 4'd4, 32'hDEAD_BEEF, 4'hF, 20, ok);
        chk("wr1_accept", ok, 1);
        chk("wr1_valids", {awvalid_o, wvalid_o, arvalid_o}, 64'b110);
        chk("wr1_payload", {awaddr_o, wdata_o}, {32'h10, 32'hDEAD_BEEF});
        chk("wr1_strb_prot", {wstrb_o, awprot_o}, {4'hF, 3'b000});
        drain("wr1_drain");

        // awready at N+1, wready only at N+4
        rdy_mode  = 0;
        awready_i = 0;
        wready_i  = 0;
        arready_i = 0;
        issue(1'b1, 4'd8, 32'hA5A5_5A5A, 4'h3, 20, ok);
        chk("wr2_accept", ok, 1);
        awready_i = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge aclk_i);
            chk($sformatf("wr2_awvalid_n%0d", k), awvalid_o, (k == 1));
            chk($sformatf("wr2_wvalid_n%0d", k), wvalid_o, (k <= 4));
            if (k <= 4) chk($sformatf("wr2_wdata_n%0d", k), {wdata_o, wstrb_o}, {32'hA5A5_5A5A, 4'h3});
            @(posedge aclk_i);
            #1;
            awready_i = 0;
            wready_i  = (k + 1 == 4);
        end
        rdy_mode = 2;
        drain("wr2_drain");

        // six reads against four credits with rvalid withheld
        reset_dut(0);
        r_hold = 1;
        for (int i = 1; i <= 4; i++) begin
            issue(1'b0, 4'(i), 32'h0, 4'h0, 20, ok);
            chk($sformatf("rd_cap_accept%0d", i), ok, 1);
        end
        issue(1'b0, 4'd5, 32'h0, 4'h0, 12, ok);
        chk("rd_cap_blocked", ok, 0);
        r_hold = 0;
        issue(1'b0, 4'd5, 32'h0, 4'h0, 200, ok);
        chk("rd_cap_accept5", ok, 1);
        issue(1'b0, 4'd6, 32'h0, 4'h0, 200, ok);
        chk("rd_cap_accept6", ok, 1);
        drain("rd_cap_drain");

        // read then write: write waits for the R handshake
        reset_dut(0);
        r_hold = 1;
        issue(1'b0, 4'd2, 32'h0, 4'h0, 20, ok);
        chk("rw_rd_accept", ok, 1);
        issue(1'b1, 4'd3, 32'h1234_5678, 4'hF, 12, ok);
        chk("rw_wr_blocked", ok, 0);
        r_hold = 0;
        issue(1'b1, 4'd3, 32'h1234_5678, 4'hF, 200, ok);
        chk("rw_wr_accept", ok, 1);
        drain("rw_drain");

        // FIFO full with yumi held low, then drain one per cycle
        reset_dut(0);
        yumi_mode = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 4'(8 + i), 32'h0, 4'h0, 20, ok);
            chk($sformatf("full_accept%0d", i), ok, 1);
        end
        repeat (20) @(posedge aclk_i);
        @(negedge aclk_i);
        chk("full_flags", {resp_v_o, rready_o, bready_o, cmd_ready_o}, 64'b1000);
        chk("full_queue", 64'(exp_q.size()), 64'd4);
        yumi_mode = 2;
        repeat (4) @(negedge aclk_i);
        chk("full_drain_last", resp_v_o, 1);
        @(negedge aclk_i);
        chk("full_drain_empty", {resp_v_o, 32'(exp_q.size())}, 64'h0);
        @(posedge aclk_i);
        #1;

        // watchdog, then reset in the middle of a read
        reset_dut(0);
        rdy_mode  = 0;
        arready_i = 0;
        r_hold    = 1;
        issue(1'b0, 4'd1, 32'h0, 4'h0, 20, ok);
        chk("wd_accept", ok, 1);
        repeat (8) @(negedge aclk_i);
        chk("wd_before", {timeout_o, arvalid_o}, 64'b01);
        @(negedge aclk_i);
        chk("wd_fire", timeout_o, 1);
        repeat (3) @(negedge aclk_i);
        chk("wd_sticky", timeout_o, 1);
        @(posedge aclk_i);
        #1;
        reset_dut(1);

        // random mixed traffic
        rdy_mode  = 1;
        yumi_mode = 1;
        for (int n = 0; n < 250; n++) begin
            issue(1'($urandom % 2), 4'($urandom % 16), $urandom, 4'($urandom % 16), 500, ok);
            chk("rand_accept", ok, 1);
            repeat ($urandom % 3) begin
                @(posedge aclk_i);
                #1;
            end
        end
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
